// File: rtl/microcode_sequencer_pkg.sv
// rtl/microcode_sequencer_pkg.sv - shared state type and fault codes for the microcode sequencer
package microcode_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    localparam logic [1:0] FAULT_NONE      = 2'd0;
    localparam logic [1:0] FAULT_OVERFLOW  = 2'd1;
    localparam logic [1:0] FAULT_UNDERFLOW = 2'd2;
    localparam logic [1:0] FAULT_WATCHDOG  = 2'd3;

endpackage

// File: rtl/microcode_return_stack.sv
// rtl/microcode_return_stack.sv - bounded LIFO of microcode return addresses
module microcode_return_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] sp_q, sp_d;
    logic [IDX_W-1:0] wr_idx, rd_idx;

    assign full     = (sp_q == DEPTH_CNT);
    assign empty    = (sp_q == '0);
    assign wr_idx   = IDX_W'(sp_q);
    assign rd_idx   = IDX_W'(sp_q - 1'b1);
    assign data_out = empty ? '0 : mem_q[rd_idx];

    // Next pointer and entry contents; clear wins, overflow/underflow requests are ignored
    always_comb begin
        mem_d = mem_q;
        sp_d  = sp_q;
        if (clear) begin
            sp_d = '0;
        end else if (push && !full) begin
            mem_d[wr_idx] = data_in;
            sp_d          = sp_q + 1'b1;
        end else if (pop && !empty) begin
            sp_d = sp_q - 1'b1;
        end
    end

    // Stack pointer register
    always_ff @(posedge clock) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Entry storage; contents are only meaningful below the pointer so no reset is needed
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/microcode_sequencer_fsm.sv
// rtl/microcode_sequencer_fsm.sv - fetch/decode/execute sequencer driving the microcode ROM
module microcode_sequencer_fsm
    import microcode_sequencer_pkg::*;
#(
    parameter int UADDR_WIDTH = 16,
    parameter int STACK_DEPTH = 4,
    parameter int MAX_UOPS    = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   instruction_ready,
    input  logic                   memory_wait,
    input  logic [UADDR_WIDTH-1:0] opcode_entry_address,
    input  logic                   uop_finish,
    input  logic                   uop_branch,
    input  logic                   uop_branch_condition,
    input  logic                   uop_call,
    input  logic                   uop_return,
    input  logic [UADDR_WIDTH-1:0] uop_target,
    output logic [UADDR_WIDTH-1:0] microcode_address,
    output logic                   microcode_rom_read_enable,
    output logic                   instruction_fetch_request,
    output logic                   program_counter_enable,
    output logic                   busy,
    output logic                   fault,
    output logic [1:0]             fault_code
);
    localparam int WD_W = $clog2(MAX_UOPS + 1);
    // Watchdog value seen on the last permitted micro-op of an instruction
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_UOPS - 1);

    state_t                 state_q, state_d;
    logic [UADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic [1:0]             code_q, code_d;
    logic                   pc_en_q, pc_en_d;

    logic                   stk_push, stk_pop, stk_clear, stk_full, stk_empty;
    logic [UADDR_WIDTH-1:0] stk_top;
    logic [UADDR_WIDTH-1:0] addr_inc;
    logic [1:0]             fault_hit;

    assign addr_inc = addr_q + 1'b1;

    microcode_return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (UADDR_WIDTH)
    ) u_stack (
        .clock    (clock),
        .reset    (reset),
        .push     (stk_push),
        .pop      (stk_pop),
        .clear    (stk_clear),
        .data_in  (addr_inc),
        .data_out (stk_top),
        .full     (stk_full),
        .empty    (stk_empty)
    );

    // Next-state logic: sequencing, micro-op priority resolution and fault detection
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wd_d      = wd_q;
        code_d    = code_q;
        pc_en_d   = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_clear = 1'b0;
        fault_hit = FAULT_NONE;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (instruction_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                addr_d    = opcode_entry_address;
                wd_d      = '0;
                stk_clear = 1'b1;
                state_d   = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (!memory_wait) begin
                    wd_d = wd_q + 1'b1;
                    if (uop_finish) begin
                        pc_en_d = 1'b1;
                        state_d = enable ? ST_FETCH : ST_IDLE;
                    end else begin
                        if (uop_return) begin
                            if (stk_empty) begin
                                fault_hit = FAULT_UNDERFLOW;
                            end else begin
                                stk_pop = 1'b1;
                                addr_d  = stk_top;
                            end
                        end else if (uop_call) begin
                            if (stk_full) begin
                                fault_hit = FAULT_OVERFLOW;
                            end else begin
                                stk_push = 1'b1;
                                addr_d   = uop_target;
                            end
                        end else if (uop_branch && uop_branch_condition) begin
                            addr_d = uop_target;
                        end else begin
                            addr_d = addr_inc;
                        end
                        // A stack fault on the same micro-op is reported in preference to the watchdog
                        if (fault_hit == FAULT_NONE && wd_q == WD_LAST) begin
                            fault_hit = FAULT_WATCHDOG;
                        end
                        if (fault_hit != FAULT_NONE) begin
                            state_d  = ST_FAULT;
                            code_d   = fault_hit;
                            addr_d   = '0;
                            stk_push = 1'b0;
                            stk_pop  = 1'b0;
                        end
                    end
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, address, watchdog, fault code and PC pulse registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wd_q    <= '0;
            code_q  <= FAULT_NONE;
            pc_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            code_q  <= code_d;
            pc_en_q <= pc_en_d;
        end
    end

    assign microcode_address         = addr_q;
    assign microcode_rom_read_enable = (state_q == ST_EXECUTE);
    assign instruction_fetch_request = (state_q == ST_FETCH);
    assign program_counter_enable    = pc_en_q;
    assign busy                      = (state_q != ST_IDLE);
    assign fault                     = (state_q == ST_FAULT);
    assign fault_code                = code_q;

endmodule

// File: tb/tb_microcode_sequencer_fsm.sv
// tb/tb_microcode_sequencer_fsm.sv - self-checking bench for the microcode sequencer
module tb_microcode_sequencer_fsm;

    localparam int AW    = 16;
    localparam int DEPTH = 4;
    localparam int MAXU  = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          instruction_ready;
    logic          memory_wait;
    logic [AW-1:0] opcode_entry_address;
    logic          uop_finish;
    logic          uop_branch;
    logic          uop_branch_condition;
    logic          uop_call;
    logic          uop_return;
    logic [AW-1:0] uop_target;
    logic [AW-1:0] microcode_address;
    logic          microcode_rom_read_enable;
    logic          instruction_fetch_request;
    logic          program_counter_enable;
    logic          busy;
    logic          fault;
    logic [1:0]    fault_code;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit            fin;
        bit            br;
        bit            cond;
        bit            call;
        bit            ret;
        logic [AW-1:0] tgt;
        int            stall;
    } uop_t;

    uop_t prog[$];

    microcode_sequencer_fsm #(
        .UADDR_WIDTH (AW),
        .STACK_DEPTH (DEPTH),
        .MAX_UOPS    (MAXU)
    ) dut (
        .clock                     (clock),
        .reset                     (reset),
        .enable                    (enable),
        .instruction_ready         (instruction_ready),
        .memory_wait               (memory_wait),
        .opcode_entry_address      (opcode_entry_address),
        .uop_finish                (uop_finish),
        .uop_branch                (uop_branch),
        .uop_branch_condition      (uop_branch_condition),
        .uop_call                  (uop_call),
        .uop_return                (uop_return),
        .uop_target                (uop_target),
        .microcode_address         (microcode_address),
        .microcode_rom_read_enable (microcode_rom_read_enable),
        .instruction_fetch_request (instruction_fetch_request),
        .program_counter_enable    (program_counter_enable),
        .busy                      (busy),
        .fault                     (fault),
        .fault_code                (fault_code)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish within the time budget");
        $fatal(1, "timeout");
    end

    task automatic clear_uop();
        uop_finish           = 1'b0;
        uop_branch           = 1'b0;
        uop_branch_condition = 1'b0;
        uop_call             = 1'b0;
        uop_return           = 1'b0;
        uop_target           = '0;
        memory_wait          = 1'b0;
    endtask

    task automatic random_uop_lines();
        uop_finish           = 1'($urandom_range(0, 1));
        uop_branch           = 1'($urandom_range(0, 1));
        uop_branch_condition = 1'($urandom_range(0, 1));
        uop_call             = 1'($urandom_range(0, 1));
        uop_return           = 1'($urandom_range(0, 1));
        uop_target           = 16'($urandom);
    endtask

    task automatic add_uop(input bit fin, input bit br, input bit cond, input bit call,
                           input bit ret, input logic [AW-1:0] tgt, input int stall);
        uop_t u;
        u.fin = fin; u.br = br; u.cond = cond; u.call = call; u.ret = ret;
        u.tgt = tgt; u.stall = stall;
        prog.push_back(u);
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        enable            = 1'b0;
        instruction_ready = 1'b0;
        clear_uop();
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || fault !== 1'b0 || fault_code !== 2'd0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b fault=%b code=%0d expected 0 0 0", busy, fault, fault_code);
        end
    endtask

    task automatic go_fetch();
        enable = 1'b1;
        @(negedge clock);
    endtask

    // Reference model computes the expected address of every executed micro-op and the outcome,
    // then the driver plays the program into the DUT and compares cycle by cycle.
    task automatic run_program(input logic [AW-1:0] entry, input bit en_end, input int ready_delay,
                               input int drop_at, output int code);
        logic [AW-1:0] exp_addr[$];
        logic [AW-1:0] stk[$];
        logic [AW-1:0] a;
        logic [AW-1:0] nxt;
        int last;
        a    = entry;
        code = 0;
        last = prog.size() - 1;
        for (int i = 0; i < prog.size(); i++) begin
            exp_addr.push_back(a);
            if (prog[i].fin) begin
                last = i;
                break;
            end
            nxt = a + 16'd1;
            if (prog[i].ret) begin
                if (stk.size() == 0) code = 2;
                else a = stk.pop_back();
            end else if (prog[i].call) begin
                if (stk.size() == DEPTH) code = 1;
                else begin
                    stk.push_back(nxt);
                    a = prog[i].tgt;
                end
            end else if (prog[i].br && prog[i].cond) begin
                a = prog[i].tgt;
            end else begin
                a = nxt;
            end
            if (code == 0 && i + 1 == MAXU) code = 3;
            if (code != 0) begin
                last = i;
                break;
            end
        end

        checks++;
        if (instruction_fetch_request !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL fetch_entry: got req=%b busy=%b expected 1 1", instruction_fetch_request, busy);
        end
        instruction_ready = 1'b0;
        for (int k = 0; k < ready_delay; k++) begin
            @(negedge clock);
            checks++;
            if (instruction_fetch_request !== 1'b1 || microcode_rom_read_enable !== 1'b0) begin
                errors++;
                $display("FAIL fetch_wait: got req=%b rd=%b expected 1 0", instruction_fetch_request, microcode_rom_read_enable);
            end
        end
        instruction_ready    = 1'b1;
        opcode_entry_address = entry;
        @(negedge clock);
        instruction_ready = 1'b0;
        checks++;
        if ({instruction_fetch_request, microcode_rom_read_enable, busy} !== 3'b001) begin
            errors++;
            $display("FAIL decode: got req/rd/busy=%b expected 001",
                     {instruction_fetch_request, microcode_rom_read_enable, busy});
        end
        @(negedge clock);
        opcode_entry_address = 16'($urandom);

        for (int i = 0; i <= last; i++) begin
            checks++;
            if (microcode_rom_read_enable !== 1'b1 || microcode_address !== exp_addr[i]) begin
                errors++;
                $display("FAIL exec_addr uop %0d: got addr=%h rd=%b expected addr=%h rd=1",
                         i, microcode_address, microcode_rom_read_enable, exp_addr[i]);
            end
            for (int s = 0; s < prog[i].stall; s++) begin
                memory_wait = 1'b1;
                random_uop_lines();
                enable = 1'($urandom_range(0, 1));
                @(negedge clock);
                checks++;
                if (microcode_address !== exp_addr[i] || microcode_rom_read_enable !== 1'b1 ||
                    program_counter_enable !== 1'b0 || fault !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold uop %0d: got addr=%h rd=%b pc=%b fault=%b expected addr=%h rd=1 pc=0 fault=0",
                             i, microcode_address, microcode_rom_read_enable, program_counter_enable, fault, exp_addr[i]);
                end
            end
            memory_wait          = 1'b0;
            uop_finish           = prog[i].fin;
            uop_branch           = prog[i].br;
            uop_branch_condition = prog[i].cond;
            uop_call             = prog[i].call;
            uop_return           = prog[i].ret;
            uop_target           = prog[i].tgt;
            if (i == last) enable = en_end;
            else if (drop_at < 0) enable = 1'($urandom_range(0, 1));
            else enable = (i < drop_at);
            @(negedge clock);
        end
        clear_uop();

        if (code == 0) begin
            checks++;
            if (program_counter_enable !== 1'b1 || fault !== 1'b0 ||
                instruction_fetch_request !== en_end || busy !== en_end) begin
                errors++;
                $display("FAIL finish: got pc=%b fault=%b req=%b busy=%b expected pc=1 fault=0 req=%b busy=%b",
                         program_counter_enable, fault, instruction_fetch_request, busy, en_end, en_end);
            end
            @(negedge clock);
            checks++;
            if (program_counter_enable !== 1'b0 || instruction_fetch_request !== en_end) begin
                errors++;
                $display("FAIL pc_pulse_width: got pc=%b req=%b expected pc=0 req=%b",
                         program_counter_enable, instruction_fetch_request, en_end);
            end
        end else begin
            for (int h = 0; h < 3; h++) begin
                checks++;
                if (fault !== 1'b1 || fault_code !== 2'(code) || busy !== 1'b1 ||
                    microcode_address !== '0 || microcode_rom_read_enable !== 1'b0 ||
                    instruction_fetch_request !== 1'b0 || program_counter_enable !== 1'b0) begin
                    errors++;
                    $display("FAIL fault_state: got fault=%b code=%0d busy=%b addr=%h rd=%b req=%b pc=%b expected fault=1 code=%0d busy=1 others 0",
                             fault, fault_code, busy, microcode_address, microcode_rom_read_enable,
                             instruction_fetch_request, program_counter_enable, code);
                end
                enable            = 1'b1;
                instruction_ready = 1'b1;
                random_uop_lines();
                @(negedge clock);
            end
            instruction_ready = 1'b0;
            clear_uop();
        end
    endtask

    task automatic test_reset();
        reset             = 1'b1;
        enable            = 1'b1;
        instruction_ready = 1'b1;
        clear_uop();
        opcode_entry_address = 16'h1234;
        repeat (2) @(negedge clock);
        checks++;
        if ({microcode_address, microcode_rom_read_enable, instruction_fetch_request,
             program_counter_enable, busy, fault, fault_code} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%h rd=%b req=%b pc=%b busy=%b fault=%b code=%0d expected all 0",
                     microcode_address, microcode_rom_read_enable, instruction_fetch_request,
                     program_counter_enable, busy, fault, fault_code);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_execute();
        go_fetch();
        instruction_ready    = 1'b1;
        opcode_entry_address = 16'h0003;
        @(negedge clock);
        instruction_ready = 1'b0;
        @(negedge clock);
        opcode_entry_address = 16'($urandom);
        uop_call   = 1'b1;
        uop_target = 16'h0005;
        @(negedge clock);
        clear_uop();
        checks++;
        if (microcode_address !== 16'h0005 || microcode_rom_read_enable !== 1'b1) begin
            errors++;
            $display("FAIL mid_exec_setup: got addr=%h rd=%b expected addr=0005 rd=1", microcode_address, microcode_rom_read_enable);
        end
        reset    = 1'b1;
        uop_call = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        enable = 1'b0;
        clear_uop();
        checks++;
        if (busy !== 1'b0 || microcode_address !== '0 || fault_code !== 2'd0 ||
            microcode_rom_read_enable !== 1'b0 || instruction_fetch_request !== 1'b0 ||
            program_counter_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_exec: got busy=%b addr=%h code=%0d rd=%b req=%b pc=%b expected all 0",
                     busy, microcode_address, fault_code, microcode_rom_read_enable,
                     instruction_fetch_request, program_counter_enable);
        end
    endtask

    task automatic test_basic();
        int code;
        do_reset(); go_fetch(); prog.delete();
        add_uop(0, 0, 0, 0, 0, 16'h0, 0);
        add_uop(0, 0, 0, 0, 0, 16'h0, 0);
        add_uop(1, 0, 0, 0, 0, 16'h0, 0);
        run_program(16'h0010, 1'b1, 0, -1, code);
    endtask

    task automatic test_branch();
        int code;
        for (int c = 0; c < 2; c++) begin
            do_reset(); go_fetch(); prog.delete();
            add_uop(0, 0, 0, 0, 0, 16'h0, 0);
            add_uop(0, 1, 1'(c), 0, 0, 16'h0020, 0);
            add_uop(1, 0, 0, 0, 0, 16'h0, 0);
            run_program(16'h0010, 1'b1, 1, -1, code);
        end
    endtask

    task automatic test_call_return();
        int code;
        do_reset(); go_fetch(); prog.delete();
        add_uop(0, 0, 0, 1, 0, 16'h0030, 0);
        add_uop(0, 0, 0, 0, 0, 16'h0, 0);
        add_uop(0, 0, 0, 0, 1, 16'h0, 0);
        add_uop(1, 0, 0, 0, 0, 16'h0, 0);
        run_program(16'h0010, 1'b0, 0, -1, code);
    endtask

    task automatic test_faults();
        int code;
        do_reset(); go_fetch(); prog.delete();
        for (int i = 0; i < 5; i++) add_uop(0, 0, 0, 1, 0, 16'h0040 + 16'(i * 16), 0);
        add_uop(1, 0, 0, 0, 0, 16'h0, 0);
        run_program(16'h0010, 1'b1, 0, -1, code);
        do_reset(); go_fetch(); prog.delete();
        add_uop(0, 0, 0, 1, 0, 16'h0050, 0);
        add_uop(0, 0, 0, 0, 1, 16'h0, 0);
        add_uop(0, 0, 0, 0, 1, 16'h0, 0);
        add_uop(1, 0, 0, 0, 0, 16'h0, 0);
        run_program(16'h0010, 1'b1, 0, -1, code);
        do_reset(); go_fetch(); prog.delete();
        for (int i = 0; i < MAXU + 1; i++) add_uop(0, 0, 0, 0, 0, 16'h0, (i == 10) ? 2 : 0);
        run_program(16'h0100, 1'b1, 0, -1, code);
    endtask

    task automatic test_watchdog_finish_wins();
        int code;
        do_reset(); go_fetch(); prog.delete();
        for (int i = 0; i < MAXU - 1; i++) add_uop(0, 0, 0, 0, 0, 16'h0, (i % 8 == 3) ? 1 : 0);
        add_uop(1, 0, 0, 0, 0, 16'h0, 0);
        run_program(16'h0200, 1'b1, 0, -1, code);
    endtask

    task automatic test_stall_and_wrap();
        int code;
        do_reset(); go_fetch(); prog.delete();
        add_uop(0, 0, 0, 0, 0, 16'h0, 0);
        add_uop(0, 0, 0, 0, 0, 16'h0, 0);
        add_uop(0, 0, 0, 0, 0, 16'h0, 3);
        add_uop(1, 0, 0, 0, 0, 16'h0, 0);
        run_program(16'h0010, 1'b1, 0, -1, code);
        prog.delete();
        add_uop(0, 0, 0, 0, 0, 16'h0, 0);
        add_uop(0, 0, 0, 1, 0, 16'h0070, 0);
        add_uop(0, 0, 0, 0, 1, 16'h0, 0);
        add_uop(1, 0, 0, 0, 0, 16'h0, 0);
        run_program(16'hFFFE, 1'b1, 2, -1, code);
    endtask

    task automatic test_enable_drop();
        int code;
        do_reset(); go_fetch(); prog.delete();
        add_uop(0, 0, 0, 0, 0, 16'h0, 0);
        add_uop(0, 0, 0, 0, 0, 16'h0, 0);
        add_uop(0, 0, 0, 0, 0, 16'h0, 0);
        add_uop(1, 0, 0, 0, 0, 16'h0, 0);
        run_program(16'h0010, 1'b0, 0, 1, code);
        instruction_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if (busy !== 1'b0 || instruction_fetch_request !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_drop: got busy=%b req=%b expected 0 0", busy, instruction_fetch_request);
            end
        end
        instruction_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int code;
        do_reset(); go_fetch();
        for (int n = 0; n < 3; n++) begin
            prog.delete();
            for (int i = 0; i < n + 1; i++) add_uop(0, 1, 1, 0, 0, 16'h0300 + 16'(n * 4 + i), 0);
            add_uop(1, 0, 0, 0, 0, 16'h0, 0);
            run_program(16'h0080 + 16'(n), 1'b1, 0, -1, code);
        end
    endtask

    task automatic gen_random(input int len);
        uop_t u;
        prog.delete();
        for (int i = 0; i < len; i++) begin
            u.fin   = (i == len - 1) || ($urandom_range(0, 99) < 3);
            u.ret   = ($urandom_range(0, 99) < 10);
            u.call  = ($urandom_range(0, 99) < 18);
            u.br    = ($urandom_range(0, 99) < 30);
            u.cond  = 1'($urandom_range(0, 1));
            u.tgt   = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 2)) : 16'($urandom);
            u.stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            prog.push_back(u);
        end
    endtask

    task automatic test_random();
        int code;
        bit in_fetch;
        bit en_end;
        do_reset();
        in_fetch = 1'b0;
        for (int n = 0; n < 60; n++) begin
            gen_random($urandom_range(1, 36));
            if (!in_fetch) go_fetch();
            en_end = 1'($urandom_range(0, 1));
            run_program(16'($urandom), en_end, $urandom_range(0, 2), -1, code);
            if (code != 0) begin
                do_reset();
                in_fetch = 1'b0;
            end else begin
                in_fetch = en_end;
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_execute();
        test_basic();
        test_branch();
        test_call_return();
        test_faults();
        test_watchdog_finish_wins();
        test_stall_and_wrap();
        test_enable_drop();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
